// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between NREQ byte requesters, the arbiter and one UART transmitter.
// The arbiter uses the slave view; the requester/transmitter side uses the master view.
interface uart_tx_arbiter_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]   req_valid_i;
    logic [NREQ*8-1:0] req_data_i;
    logic [NREQ-1:0]   req_last_i;
    logic [NREQ-1:0]   req_ready_o;
    logic              tx_valid_o;
    logic [7:0]        tx_data_o;
    logic              tx_ready_i;
    logic [NREQ-1:0]   grant_o;
    logic              abort_o;

    modport slave (
        input  req_valid_i, req_data_i, req_last_i, tx_ready_i,
        output req_ready_o, tx_valid_o, tx_data_o, grant_o, abort_o
    );

    modport master (
        output req_valid_i, req_data_i, req_last_i, tx_ready_i,
        input  req_ready_o, tx_valid_o, tx_data_o, grant_o, abort_o
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin frame arbiter: one requester at a time owns the UART byte stream until it
// sends a last byte, exceeds MAX_FRAME bytes, or stays silent for TIMEOUT cycles.
module uart_tx_arbiter #(
    parameter int NREQ      = 4,
    parameter int TIMEOUT   = 16,
    parameter int MAX_FRAME = 32
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    uart_tx_arbiter_if.slave   bus
);

    localparam int         IW        = $clog2(NREQ);
    localparam logic [7:0] TIMEOUT_B = 8'(TIMEOUT);
    localparam logic [7:0] MAX_B     = 8'(MAX_FRAME);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t          state_q;
    logic [IW-1:0]   owner_q;
    logic [IW-1:0]   last_grant_q;
    logic [NREQ-1:0] grant_q;
    logic [7:0]      byte_cnt_q;
    logic [7:0]      idle_cnt_q;

    logic [7:0]      byte_cnt_d;
    logic [7:0]      idle_cnt_d;
    logic [7:0]      req_byte [NREQ];
    logic            active;
    logic            own_valid;
    logic            own_last;
    logic            xfer;
    logic            hit_max;
    logic            hit_timeout;
    logic            release_now;
    logic            sel_found;
    logic [IW-1:0]   sel_idx;
    int              cand;

    assign active    = (state_q == ACTIVE);
    assign own_valid = bus.req_valid_i[owner_q];
    assign own_last  = bus.req_last_i[owner_q];
    assign xfer      = active && own_valid && bus.tx_ready_i;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_req
            assign req_byte[gi]        = bus.req_data_i[8*gi +: 8];
            assign bus.req_ready_o[gi] = active && (owner_q == IW'(gi)) && bus.tx_ready_i;
        end
    endgenerate

    always_comb begin
        byte_cnt_d = byte_cnt_q + 8'd1;
        idle_cnt_d = own_valid ? 8'd0 : (idle_cnt_q + 8'd1);
    end

    // A last byte always wins over the frame-length limit, so the release stays clean.
    assign hit_max     = xfer && !own_last && (byte_cnt_d == MAX_B);
    assign hit_timeout = active && !own_valid && (idle_cnt_d == TIMEOUT_B);
    assign release_now = (xfer && own_last) || hit_max || hit_timeout;

    // Search starts just after the previous owner so every requester gets a turn.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = 0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = (int'(last_grant_q) + k) % NREQ;
            if (!sel_found && bus.req_valid_i[IW'(cand)]) begin
                sel_found = 1'b1;
                sel_idx   = IW'(cand);
            end
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q      <= IDLE;
            owner_q      <= '0;
            last_grant_q <= IW'(NREQ - 1);
            grant_q      <= '0;
            byte_cnt_q   <= 8'd0;
            idle_cnt_q   <= 8'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (sel_found) begin
                        state_q    <= ACTIVE;
                        owner_q    <= sel_idx;
                        grant_q    <= {{(NREQ-1){1'b0}}, 1'b1} << sel_idx;
                        byte_cnt_q <= 8'd0;
                        idle_cnt_q <= 8'd0;
                    end
                end
                ACTIVE: begin
                    if (xfer) begin
                        byte_cnt_q <= byte_cnt_d;
                    end
                    idle_cnt_q <= idle_cnt_d;
                    if (release_now) begin
                        state_q      <= IDLE;
                        grant_q      <= '0;
                        last_grant_q <= owner_q;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    grant_q <= '0;
                end
            endcase
        end
    end

    assign bus.grant_o    = grant_q;
    assign bus.abort_o    = hit_max || hit_timeout;
    assign bus.tx_valid_o = active && own_valid;
    assign bus.tx_data_o  = (active && own_valid) ? req_byte[owner_q] : 8'h00;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: bytes and grants expected are queued when driven
// and popped when the arbiter forwards them.
module tb_uart_tx_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NREQ(4)) bus ();

    uart_tx_arbiter #(
        .NREQ(4),
        .TIMEOUT(16),
        .MAX_FRAME(32)
    ) dut (
        .wb_clk_i(clk),
        .wb_rst_i(rst),
        .bus(bus)
    );

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] exp_q[$];

    task automatic set_byte(input int k, input logic [7:0] b);
        bus.req_data_i[8*k +: 8] = b;
    endtask

    function automatic logic [7:0] pop_exp();
        if (exp_q.size() == 0) return 8'hxx;
        return exp_q.pop_front();
    endfunction

    task automatic test_reset();
        logic [7:0] none;
        rst = 1'b1;
        bus.req_valid_i = 4'hF;
        bus.req_last_i  = 4'h0;
        bus.req_data_i  = 32'h44332211;
        bus.tx_ready_i  = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        none = 8'h00;
        n_cmp++; if (bus.grant_o !== 4'b0)   begin n_bad++; $display("FAIL reset_grant: got %b expected 0000", bus.grant_o); end
        n_cmp++; if (bus.tx_valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_tx_valid: got %b expected 0", bus.tx_valid_o); end
        n_cmp++; if (bus.req_ready_o !== 4'b0) begin n_bad++; $display("FAIL reset_req_ready: got %b expected 0000", bus.req_ready_o); end
        n_cmp++; if (bus.abort_o !== 1'b0)   begin n_bad++; $display("FAIL reset_abort: got %b expected 0", bus.abort_o); end
        n_cmp++; if (bus.tx_data_o !== none) begin n_bad++; $display("FAIL reset_tx_data: got %h expected 00", bus.tx_data_o); end
        @(negedge clk);
        rst = 1'b0;
        bus.req_valid_i = 4'h0;
        $display("reset: outputs idle while held");
    endtask

    task automatic test_round_robin();
        int         exp_g[$];
        int         got = 0;
        int         g;
        logic [3:0] prev = 4'b0;
        for (int k = 0; k < 5; k++) exp_g.push_back(k % 4);
        bus.tx_ready_i = 1'b1;
        bus.req_last_i = 4'hF;
        for (int k = 0; k < 4; k++) set_byte(k, 8'h10 + 8'(k));
        bus.req_valid_i = 4'hF;
        for (int cyc = 0; cyc < 40 && got < 5; cyc++) begin
            @(negedge clk);
            #1;
            if (bus.grant_o != 4'b0) begin
                g = exp_g.pop_front();
                n_cmp++; if (bus.grant_o !== 4'(1 << g)) begin n_bad++; $display("FAIL rr_grant: got %b expected %b", bus.grant_o, 4'(1 << g)); end
                n_cmp++; if (prev !== 4'b0) begin n_bad++; $display("FAIL rr_idle_gap: previous grant %b expected 0000", prev); end
                n_cmp++; if (bus.tx_data_o !== 8'h10 + 8'(g)) begin n_bad++; $display("FAIL rr_data: got %h expected %h", bus.tx_data_o, 8'h10 + 8'(g)); end
                $display("round_robin: grant %b data %h", bus.grant_o, bus.tx_data_o);
                got++;
            end
            prev = bus.grant_o;
        end
        n_cmp++; if (got != 5) begin n_bad++; $display("FAIL rr_count: got %0d grants expected 5", got); end
        @(negedge clk);
        bus.req_valid_i = 4'h0;
        bus.req_last_i  = 4'h0;
    endtask

    task automatic test_frame();
        logic [7:0] b[3] = '{8'hDE, 8'h1B, 8'h2A};
        int   idx = 0, pushed = -1, strobes = 0, aborts = 0;
        bit   done = 0;
        logic rdy = 1'b1;
        logic [7:0] e;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            @(negedge clk);
            bus.req_valid_i[2] = 1'b1;
            set_byte(2, b[idx]);
            bus.req_last_i[2]  = (idx == 2);
            bus.tx_ready_i     = rdy;
            if (idx != pushed) begin exp_q.push_back(b[idx]); pushed = idx; end
            #1;
            if (bus.req_ready_o[2]) strobes++;
            if (bus.abort_o) aborts++;
            n_cmp++; if ((bus.req_ready_o & 4'b1011) !== 4'b0) begin n_bad++; $display("FAIL frame_other_ready: got %b expected x0xx zeros", bus.req_ready_o); end
            if (bus.tx_valid_o && bus.tx_ready_i) begin
                e = pop_exp();
                n_cmp++; if (bus.tx_data_o !== e) begin n_bad++; $display("FAIL frame_data: got %h expected %h", bus.tx_data_o, e); end
                $display("frame: req2 byte %h", bus.tx_data_o);
                if (idx == 2) done = 1; else idx++;
            end
            rdy = ~rdy;
        end
        @(negedge clk);
        bus.req_valid_i = 4'h0;
        bus.req_last_i  = 4'h0;
        bus.tx_ready_i  = 1'b1;
        n_cmp++; if (!done) begin n_bad++; $display("FAIL frame_complete: got %0d bytes expected 3", idx); end
        n_cmp++; if (strobes != 3) begin n_bad++; $display("FAIL frame_strobes: got %0d expected 3", strobes); end
        n_cmp++; if (aborts != 0) begin n_bad++; $display("FAIL frame_abort: got %0d expected 0", aborts); end
    endtask

    task automatic test_timeout();
        bit         gr = 0;
        int         abort_at = 0;
        logic [3:0] grant_at_abort = 4'b0;
        logic [7:0] e;
        bus.tx_ready_i  = 1'b1;
        set_byte(1, 8'h55);
        set_byte(2, 8'hA2);
        bus.req_last_i  = 4'b0100;
        bus.req_valid_i = 4'b0110;
        exp_q.push_back(8'h55);
        exp_q.push_back(8'hA2);
        for (int i = 0; i < 5 && !gr; i++) begin
            @(negedge clk);
            #1;
            if (bus.grant_o == 4'b0010) gr = 1;
        end
        n_cmp++; if (!gr) begin n_bad++; $display("FAIL to_grant1: got %b expected 0010", bus.grant_o); end
        e = pop_exp();
        n_cmp++; if (bus.tx_data_o !== e) begin n_bad++; $display("FAIL to_byte: got %h expected %h", bus.tx_data_o, e); end
        for (int i = 1; i <= 20 && abort_at == 0; i++) begin
            @(negedge clk);
            bus.req_valid_i[1] = 1'b0;
            #1;
            n_cmp++; if (bus.tx_valid_o !== 1'b0) begin n_bad++; $display("FAIL to_ignored_valid: got %b expected 0 at idle %0d", bus.tx_valid_o, i); end
            if (bus.abort_o) begin abort_at = i; grant_at_abort = bus.grant_o; end
        end
        $display("timeout: abort on idle cycle %0d", abort_at);
        n_cmp++; if (abort_at != 16) begin n_bad++; $display("FAIL to_abort_cycle: got %0d expected 16", abort_at); end
        n_cmp++; if (grant_at_abort !== 4'b0010) begin n_bad++; $display("FAIL to_grant_at_abort: got %b expected 0010", grant_at_abort); end
        @(negedge clk);
        #1;
        n_cmp++; if (bus.grant_o !== 4'b0) begin n_bad++; $display("FAIL to_release: got %b expected 0000", bus.grant_o); end
        n_cmp++; if (bus.abort_o !== 1'b0) begin n_bad++; $display("FAIL to_abort_width: got %b expected 0", bus.abort_o); end
        @(negedge clk);
        #1;
        n_cmp++; if (bus.grant_o !== 4'b0100) begin n_bad++; $display("FAIL to_grant2: got %b expected 0100", bus.grant_o); end
        e = pop_exp();
        n_cmp++; if (bus.tx_data_o !== e) begin n_bad++; $display("FAIL to_req2_byte: got %h expected %h", bus.tx_data_o, e); end
        $display("timeout: req2 granted, byte %h", bus.tx_data_o);
        @(negedge clk);
        bus.req_valid_i = 4'h0;
        bus.req_last_i  = 4'h0;
    endtask

    task automatic test_max_frame();
        int         i = 0, pushed = -1, aborts = 0, bytes_at_abort = -1;
        int         abort_cyc = -1, regrant_cyc = -1, rises = 0, cyc;
        logic [3:0] prev = 4'b0;
        logic [7:0] e;
        bus.tx_ready_i = 1'b1;
        for (cyc = 0; cyc < 150 && i < 40; cyc++) begin
            @(negedge clk);
            bus.req_valid_i[3] = 1'b1;
            set_byte(3, 8'(i + 1));
            bus.req_last_i[3]  = (i == 39);
            if (i != pushed) begin exp_q.push_back(8'(i + 1)); pushed = i; end
            #1;
            if (bus.grant_o == 4'b1000 && prev == 4'b0) begin
                rises++;
                if (rises == 2) regrant_cyc = cyc;
            end
            if (bus.abort_o) begin aborts++; abort_cyc = cyc; bytes_at_abort = i + 1; end
            if (bus.tx_valid_o && bus.tx_ready_i) begin
                e = pop_exp();
                n_cmp++; if (bus.tx_data_o !== e) begin n_bad++; $display("FAIL mf_data: got %h expected %h", bus.tx_data_o, e); end
                i++;
            end
            prev = bus.grant_o;
        end
        @(negedge clk);
        bus.req_valid_i = 4'h0;
        bus.req_last_i  = 4'h0;
        #1;
        $display("max_frame: %0d bytes, abort after byte %0d, regrant gap %0d", i, bytes_at_abort, regrant_cyc - abort_cyc);
        n_cmp++; if (i != 40) begin n_bad++; $display("FAIL mf_bytes: got %0d expected 40", i); end
        n_cmp++; if (aborts != 1) begin n_bad++; $display("FAIL mf_abort_count: got %0d expected 1", aborts); end
        n_cmp++; if (bytes_at_abort != 32) begin n_bad++; $display("FAIL mf_abort_byte: got %0d expected 32", bytes_at_abort); end
        n_cmp++; if (rises != 2) begin n_bad++; $display("FAIL mf_grants: got %0d expected 2", rises); end
        n_cmp++; if (regrant_cyc - abort_cyc != 2) begin n_bad++; $display("FAIL mf_regrant_gap: got %0d expected 2", regrant_cyc - abort_cyc); end
        n_cmp++; if (bus.grant_o !== 4'b0) begin n_bad++; $display("FAIL mf_final_release: got %b expected 0000", bus.grant_o); end
    endtask

    task automatic test_max_last();
        int         i = 0, pushed = -1, aborts = 0;
        logic [7:0] e;
        bus.tx_ready_i = 1'b1;
        for (int cyc = 0; cyc < 100 && i < 32; cyc++) begin
            @(negedge clk);
            bus.req_valid_i[0] = 1'b1;
            set_byte(0, 8'hA0 ^ 8'(i));
            bus.req_last_i[0]  = (i == 31);
            if (i != pushed) begin exp_q.push_back(8'hA0 ^ 8'(i)); pushed = i; end
            #1;
            if (bus.abort_o) aborts++;
            if (bus.tx_valid_o && bus.tx_ready_i) begin
                e = pop_exp();
                n_cmp++; if (bus.tx_data_o !== e) begin n_bad++; $display("FAIL ml_data: got %h expected %h", bus.tx_data_o, e); end
                i++;
            end
        end
        @(negedge clk);
        bus.req_valid_i = 4'h0;
        bus.req_last_i  = 4'h0;
        #1;
        $display("max_last: %0d bytes, %0d aborts", i, aborts);
        n_cmp++; if (i != 32) begin n_bad++; $display("FAIL ml_bytes: got %0d expected 32", i); end
        n_cmp++; if (aborts != 0) begin n_bad++; $display("FAIL ml_abort: got %0d expected 0", aborts); end
        n_cmp++; if (bus.grant_o !== 4'b0) begin n_bad++; $display("FAIL ml_release: got %b expected 0000", bus.grant_o); end
    endtask

    task automatic test_reset_midframe();
        bit         gr = 0;
        int         bp_bad = 0;
        logic [7:0] e;
        bus.tx_ready_i  = 1'b0;
        set_byte(1, 8'h77);
        bus.req_valid_i = 4'b0010;
        for (int i = 0; i < 5 && !gr; i++) begin
            @(negedge clk);
            #1;
            if (bus.grant_o == 4'b0010) gr = 1;
        end
        n_cmp++; if (!gr) begin n_bad++; $display("FAIL rm_grant1: got %b expected 0010", bus.grant_o); end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            n_cmp++;
            if (bus.grant_o !== 4'b0010 || bus.abort_o !== 1'b0 || bus.tx_valid_o !== 1'b1) begin
                n_bad++; bp_bad++;
                $display("FAIL rm_backpressure: got grant %b abort %b valid %b expected 0010 0 1", bus.grant_o, bus.abort_o, bus.tx_valid_o);
            end
        end
        $display("reset_midframe: 20 backpressure cycles, %0d bad", bp_bad);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_cmp++; if (bus.grant_o !== 4'b0) begin n_bad++; $display("FAIL rm_grant_drop: got %b expected 0000", bus.grant_o); end
        n_cmp++; if (bus.tx_valid_o !== 1'b0) begin n_bad++; $display("FAIL rm_valid_drop: got %b expected 0", bus.tx_valid_o); end
        n_cmp++; if (bus.abort_o !== 1'b0) begin n_bad++; $display("FAIL rm_abort: got %b expected 0", bus.abort_o); end
        @(negedge clk);
        rst = 1'b0;
        bus.tx_ready_i  = 1'b1;
        bus.req_last_i  = 4'hF;
        for (int k = 0; k < 4; k++) set_byte(k, 8'hC0 + 8'(k));
        bus.req_valid_i = 4'hF;
        exp_q.push_back(8'hC0);
        gr = 0;
        for (int i = 0; i < 5 && !gr; i++) begin
            @(negedge clk);
            #1;
            if (bus.grant_o != 4'b0) gr = 1;
        end
        e = pop_exp();
        n_cmp++; if (bus.grant_o !== 4'b0001) begin n_bad++; $display("FAIL rm_first_winner: got %b expected 0001", bus.grant_o); end
        n_cmp++; if (bus.tx_data_o !== e) begin n_bad++; $display("FAIL rm_first_byte: got %h expected %h", bus.tx_data_o, e); end
        $display("reset_midframe: after reset grant %b byte %h", bus.grant_o, bus.tx_data_o);
        @(negedge clk);
        bus.req_valid_i = 4'h0;
        bus.req_last_i  = 4'h0;
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_frame();
        test_timeout();
        test_max_frame();
        test_max_last();
        test_reset_midframe();
        repeat (2) @(negedge clk);
        n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL scoreboard_leftover: got %0d entries expected 0", exp_q.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, expected completion");
        $fatal(1, "time limit reached");
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, meaning the number of requesters (2..8).
REQ-002 The block SHALL have parameter TIMEOUT, default 16, meaning the idle cycles tolerated inside a granted frame (1..255).
REQ-003 The block SHALL have parameter MAX_FRAME, default 32, meaning the maximum bytes per grant (1..255).
REQ-004 The block SHALL have port wb_clk_i  input  1  system clock; all state changes on its rising edge.
REQ-005 The block SHALL have port wb_rst_i  input  1  asynchronous, active-high reset.
REQ-006 The block SHALL have port req_valid_i  input  NREQ  per-requester byte-available flag.
REQ-007 The block SHALL have port req_data_i  input  NREQ*8  per-requester byte; requester k occupies bits [8k+7:8k].
REQ-008 The block SHALL have port req_last_i  input  NREQ  per-requester flag marking the last byte of a frame.
REQ-009 The block SHALL have port req_ready_o  output  NREQ  per-requester byte-accepted strobe.
REQ-010 The block SHALL have port tx_valid_o  output  1  byte valid toward the UART transmitter.
REQ-011 The block SHALL have port tx_data_o  output  8  byte toward the UART transmitter.
REQ-012 The block SHALL have port tx_ready_i  input  1  UART transmitter can accept a byte.
REQ-013 The block SHALL have port grant_o  output  NREQ  one-hot current owner; all zero when idle.
REQ-014 The block SHALL have port abort_o  output  1  one-cycle pulse on forced release.

Function
REQ-015 The block SHALL implement states IDLE and ACTIVE.
REQ-016 In IDLE: grant_o=0, tx_valid_o=0, req_ready_o=0.
REQ-017 In IDLE with any req_valid_i set, the block SHALL select the first set requester searching from last_grant+1 upward, modulo NREQ, register it in grant_o and enter ACTIVE on the next edge.
REQ-018 Grant latency SHALL be exactly one cycle from request to grant_o assertion.
REQ-019 In ACTIVE with owner g, tx_valid_o=req_valid_i[g] and tx_data_o=req_data_i[g] (combinational).
REQ-020 In ACTIVE with owner g, req_ready_o[g]=tx_ready_i; all other req_ready_o bits SHALL be 0.
REQ-021 A transfer SHALL occur on a cycle with tx_valid_o and tx_ready_i both high.
REQ-022 tx_data_o SHALL be 0 whenever tx_valid_o=0.
REQ-023 An 8-bit byte counter SHALL clear on grant and increment on each transfer.
REQ-024 A transfer with req_last_i[g]=1 SHALL return the block to IDLE, set last_grant=g and clear grant_o on the next edge, without an abort_o pulse.
REQ-025 A transfer that brings the byte count to MAX_FRAME without req_last_i SHALL release the grant as in REQ-024 and pulse abort_o.
REQ-026 An 8-bit idle counter SHALL increment each ACTIVE cycle with req_valid_i[g]=0, and SHALL clear on any cycle with req_valid_i[g]=1.
REQ-027 When the idle counter reaches TIMEOUT, the block SHALL release the grant and pulse abort_o.
REQ-028 Cycles with req_valid_i[g]=1 and tx_ready_i=0 SHALL be backpressure, not idle, and SHALL never time out.
REQ-029 When req_last_i and the MAX_FRAME limit coincide on one transfer, the release SHALL be a normal release with no abort.
REQ-030 The block SHALL spend at least one IDLE cycle between consecutive grants, including re-grants to the same requester.
REQ-031 Requests from non-owners SHALL be ignored during ACTIVE, with no queuing side effects.
REQ-032 req_data_i and req_last_i SHALL be sampled only from the owner.

Reset
REQ-033 On wb_rst_i=1, asynchronously: state=IDLE, grant_o=0, abort_o=0, counters=0, last_grant=NREQ-1 (requester 0 wins first).
REQ-034 A reset asserted mid-frame SHALL drop the frame without an abort_o pulse; tx_valid_o SHALL fall in the same cycle.

Verification
REQ-035 Reset release, then req_valid_i=4'b1111 held, every byte last, tx_ready_i=1 -> grant sequence 0,1,2,3,0, one IDLE cycle between each grant.
REQ-036 Requester 2 sends 3 bytes 0xDE,0x1B,0x2A, last on 0x2A, with tx_ready_i toggling 1,0 -> tx_data_o shows the bytes in order, exactly 3 req_ready_o[2] strobes, no abort.
REQ-037 Owner 1 drops valid after one byte -> abort_o pulses on idle cycle 16, grant_o=0 the next cycle, and requester 2 is granted if pending.
REQ-038 Owner streams 40 bytes without last, MAX_FRAME=32 -> release plus abort after byte 32; re-grant to the same requester after one IDLE cycle if it is the only requester.
REQ-039 Byte 32 carries last -> normal release, abort_o stays 0.
REQ-040 wb_rst_i pulsed mid-frame while tx_ready_i=0 -> grant_o=0 and tx_valid_o=0 immediately; after release, requester 0 wins a 4-way contention.
